// File: rtl/branch_resolver.sv
// branch_resolver: execute-side check of fetch-stage branch predictions.
//
// Fetch pushes each instruction's prediction into a small in-order queue;
// execute pops the oldest entry with the resolved outcome. A mismatch in
// predicted next PC (or a PC desync) flushes the queue and raises a
// one-cycle registered redirect. Every resolved conditional branch also
// produces a one-cycle training strobe for the predictor.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   f_valid/f_ready     fetch push handshake
//   f_PC, f_found, f_pred_take, f_pred_address   pushed prediction
//   e_valid             execute pops oldest entry with its outcome
//   e_PC, e_is_branch, e_taken, e_target         resolved outcome
//   redirect, redirect_pc                        one-cycle flush + new PC
//   upd_valid, upd_pc, upd_target, upd_taken     predictor training
//   branch_cnt, mispred_cnt                      saturating statistics
//   underflow           sticky: e_valid arrived with an empty queue

module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    output logic             f_ready,
    input  logic [31:0]      f_PC,
    input  logic             f_found,
    input  logic             f_pred_take,
    input  logic [31:0]      f_pred_address,
    input  logic             e_valid,
    input  logic [31:0]      e_PC,
    input  logic             e_is_branch,
    input  logic             e_taken,
    input  logic [31:0]      e_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Queue storage; contents are only meaningful between the pointers.
    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] pc_mem_d    [DEPTH];
    logic        found_mem_q [DEPTH];
    logic        found_mem_d [DEPTH];
    logic        take_mem_q  [DEPTH];
    logic        take_mem_d  [DEPTH];
    logic [31:0] addr_mem_q  [DEPTH];
    logic [31:0] addr_mem_d  [DEPTH];

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        upd_valid_q, upd_valid_d;
    logic [31:0] upd_pc_q, upd_pc_d;
    logic [31:0] upd_target_q, upd_target_d;
    logic        upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic        underflow_q, underflow_d;

    logic        active;
    logic        empty;
    logic        full;
    logic        ev;
    logic        pop;
    logic        push;
    logic        mispred;
    logic        upd;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [31:0] ent_pc;
    logic        ent_found;
    logic        ent_take;
    logic [31:0] ent_addr;
    logic [31:0] pred_next;
    logic [31:0] act_next;

    // Queue status and mispredict detection.
    always_comb begin
        // During the redirect cycle both sides are on the wrong path.
        active = !redirect_q;
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_idx = rd_ptr_q[AW-1:0];
        wr_idx = wr_ptr_q[AW-1:0];

        // A full queue is never empty, so e_valid frees a slot.
        f_ready = active && (!full || e_valid);
        ev      = active && e_valid;
        pop     = ev && !empty;
        push    = active && f_valid && (!full || e_valid);

        // Empty queue: behave as if the entry had no prediction.
        ent_pc    = empty ? e_PC : pc_mem_q[rd_idx];
        ent_found = !empty && found_mem_q[rd_idx];
        ent_take  = !empty && take_mem_q[rd_idx];
        ent_addr  = empty ? 32'd0 : addr_mem_q[rd_idx];

        pred_next = (ent_found && ent_take) ? ent_addr
                                            : ent_pc + 32'd4;
        act_next  = (e_is_branch && e_taken) ? e_target
                                             : e_PC + 32'd4;

        mispred = ev && ((pred_next != act_next) || (ent_pc != e_PC));
        upd     = ev && e_is_branch;
    end

    // Next-state computation.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        found_mem_d = found_mem_q;
        take_mem_d  = take_mem_q;
        addr_mem_d  = addr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (mispred) begin
            // Flush; a same-cycle push is wrong-path and is dropped.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_idx]    = f_PC;
                found_mem_d[wr_idx] = f_found;
                take_mem_d[wr_idx]  = f_pred_take;
                addr_mem_d[wr_idx]  = f_pred_address;
                wr_ptr_d            = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        redirect_d    = mispred;
        redirect_pc_d = mispred ? act_next : 32'd0;

        upd_valid_d  = upd;
        upd_pc_d     = upd ? e_PC : 32'd0;
        upd_target_d = upd ? e_target : 32'd0;
        upd_taken_d  = upd && e_taken;

        branch_cnt_d = branch_cnt_q;
        if (upd && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        mispred_cnt_d = mispred_cnt_q;
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end

        underflow_d = underflow_q || (ev && empty);
    end

    // Queue data needs no reset: it is only read between the pointers.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        found_mem_q <= found_mem_d;
        take_mem_q  <= take_mem_d;
        addr_mem_q  <= addr_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_taken_q   <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_taken_q   <= upd_taken_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            underflow_q   <= underflow_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_target  = upd_target_q;
    assign upd_taken   = upd_taken_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign underflow   = underflow_q;

endmodule
